// File: rtl/ifetch_buf_if.sv
// Fetch-stage bundle: PC register link, instruction memory req/gnt/rvalid bus and decode handshake.
// The id_exc_o signal exists only when IFETCH_MISALIGN_CHK_EN is defined.
interface ifetch_buf_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] pc_addr_i;
    logic                  jump_en_i;
    logic                  pc_stall_o;
    logic                  imem_req_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic                  imem_gnt_i;
    logic                  imem_rvalid_i;
    logic [INST_WIDTH-1:0] imem_rdata_i;
    logic                  id_valid_o;
    logic                  id_ready_i;
    logic [ADDR_WIDTH-1:0] id_pc_o;
    logic [INST_WIDTH-1:0] id_inst_o;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic                  id_exc_o;
`endif

    modport slave (
        input  pc_addr_i, jump_en_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
`ifdef IFETCH_MISALIGN_CHK_EN
        output id_exc_o,
`endif
        output pc_stall_o, imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o
    );

    modport master (
        output pc_addr_i, jump_en_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
`ifdef IFETCH_MISALIGN_CHK_EN
        input  id_exc_o,
`endif
        input  pc_stall_o, imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o
    );
endinterface

// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: credit-limited req/gnt fetch, in-order response FIFO to decode,
// stale-response discard on jump. Optional misaligned-PC trap: define IFETCH_MISALIGN_CHK_EN.
module ifetch_buf #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic        clk,
    input logic        rst,
    ifetch_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

    logic [ADDR_WIDTH-1:0] r_tag_mem  [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];

    logic [PW-1:0] r_tag_wr, r_tag_rd, r_wr, r_rd;
    logic [CW-1:0] r_count, r_outstanding, r_discard;

    logic [CW:0]           w_used;
    logic                  w_credit, w_misalign, w_exc_push;
    logic                  w_req, w_accept, w_rsp_keep, w_push, w_valid, w_pop;
    logic [ADDR_WIDTH-1:0] w_push_pc;
    logic [INST_WIDTH-1:0] w_push_inst;

    // Buffered and in-flight fetches (including ones to be discarded) share the credit pool.
    assign w_used   = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_credit = w_used < (CW + 1)'(DEPTH);

`ifdef IFETCH_MISALIGN_CHK_EN
    logic r_exc_sent;
    logic r_exc_mem [DEPTH];

    // The trap entry waits for the pipe to drain so it stays in program order, and is sent once.
    assign w_misalign = |bus.pc_addr_i[1:0];
    assign w_exc_push = !rst && !bus.jump_en_i && w_misalign && !r_exc_sent
                        && (r_outstanding == '0) && w_credit;
`else
    assign w_misalign = 1'b0;
    assign w_exc_push = 1'b0;
`endif

    assign w_req       = !rst && !bus.jump_en_i && w_credit && !w_misalign;
    assign w_accept    = w_req && bus.imem_gnt_i;
    assign w_rsp_keep  = bus.imem_rvalid_i && !bus.jump_en_i && (r_discard == '0);
    assign w_push      = w_rsp_keep || w_exc_push;
    assign w_valid     = r_count != '0;
    assign w_pop       = w_valid && bus.id_ready_i && !bus.jump_en_i;
    assign w_push_pc   = w_exc_push ? bus.pc_addr_i : r_tag_mem[r_tag_rd];
    assign w_push_inst = w_exc_push ? NOP : bus.imem_rdata_i;

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = bus.pc_addr_i;
    assign bus.pc_stall_o  = !w_accept;
    assign bus.id_valid_o  = w_valid;
    assign bus.id_pc_o     = w_valid ? r_pc_mem[r_rd] : '0;
    assign bus.id_inst_o   = w_valid ? r_inst_mem[r_rd] : NOP;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_mem[r_tag_wr] <= bus.pc_addr_i;
        end
        if (w_push) begin
            r_pc_mem[r_wr]   <= w_push_pc;
            r_inst_mem[r_wr] <= w_push_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_wr          <= '0;
            r_rd          <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (bus.jump_en_i) begin
            // Every fetch still in flight belongs to the old path; their tags are dead too.
            r_tag_rd      <= r_tag_wr;
            r_wr          <= '0;
            r_rd          <= '0;
            r_count       <= '0;
            r_outstanding <= r_outstanding - CW'(bus.imem_rvalid_i);
            r_discard     <= r_outstanding - CW'(bus.imem_rvalid_i);
        end else begin
            if (w_accept)   r_tag_wr <= r_tag_wr + 1'b1;
            if (w_rsp_keep) r_tag_rd <= r_tag_rd + 1'b1;
            if (w_push)     r_wr     <= r_wr + 1'b1;
            if (w_pop)      r_rd     <= r_rd + 1'b1;
            if (bus.imem_rvalid_i && (r_discard != '0)) begin
                r_discard <= r_discard - 1'b1;
            end
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(bus.imem_rvalid_i);
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_exc_mem[r_wr] <= w_exc_push;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.jump_en_i) begin
            r_exc_sent <= 1'b0;
        end else if (w_exc_push) begin
            r_exc_sent <= 1'b1;
        end
    end

    assign bus.id_exc_o = w_valid && r_exc_mem[r_rd];
`endif
endmodule

// File: tb/tb_ifetch_buf.sv
// Randomized bench for ifetch_buf: memory with random in-order latency, random jumps and
// back-pressure, compared against a queue-based model of what decode should receive.
module tb_ifetch_buf;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_buf_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

    ifetch_buf #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef struct {
        logic [31:0] pc;
        int          epoch;
        int          due;
    } fetch_t;

    entry_t      exp_q[$];   // what decode should see, in order
    fetch_t      mem_q[$];   // every granted fetch not yet answered by memory
    int          epoch = 0;
    int          cyc   = 0;
    logic [31:0] pc    = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic idle_inputs();
        bus.pc_addr_i     = pc;
        bus.jump_en_i     = 1'b0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.id_ready_i    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pc  = '0;
        idle_inputs();
        @(negedge clk);
        #1;
        check("rst_req",   bus.imem_req_o, 1'b0);
        check("rst_stall", bus.pc_stall_o, 1'b1);
        check("rst_valid", bus.id_valid_o, 1'b0);
        check("rst_pc",    bus.id_pc_o, '0);
        check("rst_inst",  bus.id_inst_o, NOP);
        rst = 1'b0;
        exp_q.delete();
        mem_q.delete();
        $display("reset applied");
    endtask

    // One clock of randomized traffic; probabilities are in percent.
    task automatic step(input int p_gnt, input int p_rdy, input int p_jump, input int p_rsp,
                        input int max_lat);
        fetch_t f;
        entry_t e;
        logic   exp_req, exp_valid, rsp, acc, pop, jmp, gnt, rdy;
        @(negedge clk);
        jmp = ($urandom_range(99) < p_jump);
        gnt = ($urandom_range(99) < p_gnt);
        rdy = ($urandom_range(99) < p_rdy);
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < p_rsp);
        bus.pc_addr_i     = pc;
        bus.jump_en_i     = jmp;
        bus.imem_gnt_i    = gnt;
        bus.id_ready_i    = rdy;
        bus.imem_rvalid_i = rsp;
        bus.imem_rdata_i  = rsp ? mem_word(mem_q[0].pc) : $urandom;
        #1;
        exp_req   = !jmp && ((exp_q.size() + mem_q.size()) < DEPTH);
        exp_valid = exp_q.size() > 0;
        check("req",   bus.imem_req_o, exp_req);
        check("stall", bus.pc_stall_o, !(exp_req && gnt));
        check("addr",  bus.imem_addr_o, pc);
        check("valid", bus.id_valid_o, exp_valid);
        if (exp_valid) begin
            check("id_pc",   bus.id_pc_o, exp_q[0].pc);
            check("id_inst", bus.id_inst_o, exp_q[0].inst);
`ifdef IFETCH_MISALIGN_CHK_EN
            check("id_exc", bus.id_exc_o, 1'b0);
`endif
        end else begin
            check("nop_inst", bus.id_inst_o, NOP);
        end
        acc = exp_req && gnt;
        pop = exp_valid && rdy && !jmp;
        if (pop) begin
            e = exp_q.pop_front();
            $display("decode pc=%08h inst=%08h", e.pc, e.inst);
        end
        if (rsp) begin
            f = mem_q.pop_front();
            if (!jmp && f.epoch == epoch) begin
                exp_q.push_back('{pc: f.pc, inst: mem_word(f.pc)});
            end
        end
        if (acc) begin
            mem_q.push_back('{pc: pc, epoch: epoch, due: cyc + $urandom_range(max_lat, 1)});
            pc = pc + 32'd4;
        end
        if (jmp) begin
            exp_q.delete();
            epoch++;
            pc = $urandom & 32'hFFFF_FFFC;
            $display("jump to %08h", pc);
        end
        cyc++;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        for (int i = 0; i < 20; i++) step(100, 100, 0, 100, 1);   // streaming, 1-cycle memory
        for (int i = 0; i < 12; i++) step(100, 0, 0, 100, 1);     // decode stalled: fill up
        for (int i = 0; i < 20; i++) step(100, 100, 0, 100, 1);   // drain and resume
        for (int i = 0; i < 30; i++) step(30, 100, 0, 100, 2);    // sparse grants
        for (int i = 0; i < 500; i++) step(70, 70, 5, 70, 3);
        for (int i = 0; i < 300; i++) step(90, 50, 15, 90, 2);    // jump-heavy
        do_reset();
        for (int i = 0; i < 300; i++) step(80, 60, 8, 60, 4);

`ifdef IFETCH_MISALIGN_CHK_EN
        do_reset();
        @(negedge clk);
        idle_inputs();
        bus.pc_addr_i  = 32'h6;
        bus.imem_gnt_i = 1'b1;
        #1;
        check("mis_req",   bus.imem_req_o, 1'b0);
        check("mis_stall", bus.pc_stall_o, 1'b1);
        @(negedge clk);
        #1;
        check("mis_valid", bus.id_valid_o, 1'b1);
        check("mis_pc",    bus.id_pc_o, 32'h6);
        check("mis_inst",  bus.id_inst_o, NOP);
        check("mis_exc",   bus.id_exc_o, 1'b1);
        check("mis_req2",  bus.imem_req_o, 1'b0);
        $display("misaligned pc=00000006 trapped");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
